// File: rtl/sd_frame_seq_if.sv
// Action/flow-control link between the frame sequencer and sd_if.
// Op bits and image index are registered by sd_if on if_begin.
interface sd_frame_seq_if;
  logic       init;
  logic       read_cmd;
  logic       stream_512B;
  logic       end_of_frame;
  logic [3:0] img_id;
  logic       if_begin;
  logic       if_busy;

  modport master (
    output init, read_cmd, stream_512B,
    output end_of_frame, img_id, if_begin,
    input  if_busy
  );

  modport slave (
    input  init, read_cmd, stream_512B,
    input  end_of_frame, img_id, if_begin,
    output if_busy
  );
endinterface

// File: rtl/sd_frame_seq.sv
// Card init and whole-frame fetch sequencer in front of sd_if.
// Each op runs SETUP, GO, ACK, RUN; a frame is {read, stream} per block.
module sd_frame_seq #(
  parameter int          FRAME_BLKS = 300,
  parameter int          ACK_TMO    = 16,
  parameter logic [23:0] RUN_TMO    = 24'hFFFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_req,
  input  logic       frame_req,
  input  logic [3:0] img_sel,
  input  logic       abort,
  output logic       ctl_busy,
  output logic       init_ok,
  output logic       init_done,
  output logic       frame_done,
  output logic       aborted,
  output logic       err,
  output logic [8:0] blk_cnt,
  sd_frame_seq_if.master sd
);

  localparam int         AW   = $clog2(ACK_TMO + 1);
  localparam logic [8:0] LAST = 9'(FRAME_BLKS - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, GO, ACK, RUN, DONE, ERR
  } state_t;

  state_t        state, nxt;
  logic [2:0]    op;
  logic          eof;
  logic          abort_pend;
  logic [3:0]    img;
  logic [AW-1:0] ack_cnt;
  logic [23:0]   run_cnt;
  logic          start_init;
  logic          start_frame;
  logic          ack_tmo;
  logic          run_tmo;

  assign start_init  = state == IDLE && init_req;
  assign start_frame = state == IDLE && !init_req
                    && frame_req && init_ok && !err;
  assign ack_tmo = ack_cnt == AW'(ACK_TMO - 1);
  assign run_tmo = RUN_TMO != 24'd0
                && run_cnt == RUN_TMO - 24'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start_init || start_frame) nxt = SETUP;
      SETUP: nxt = GO;
      GO:    nxt = ACK;
      ACK: begin
        if (sd.if_busy)   nxt = RUN;
        else if (ack_tmo) nxt = ERR;
      end
      RUN: begin
        if (!sd.if_busy) begin
          if (op[0])             nxt = IDLE;
          else if (op[2] && eof) nxt = DONE;
          else                   nxt = SETUP;
        end else if (run_tmo) begin
          nxt = ERR;
        end
      end
      DONE:    nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ctl_busy    = state != IDLE;
    sd.if_begin = state == GO;
    frame_done  = state == DONE;
    aborted     = state == DONE && abort_pend;
  end

  // op = {stream, read, init}; nonzero only while an op is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op         <= 3'b000;
      eof        <= 1'b0;
      abort_pend <= 1'b0;
      img        <= 4'd0;
      blk_cnt    <= 9'd0;
      init_ok    <= 1'b0;
      init_done  <= 1'b0;
      err        <= 1'b0;
      ack_cnt    <= '0;
      run_cnt    <= 24'd0;
    end else begin
      init_done <= 1'b0;
      ack_cnt   <= state == ACK ? ack_cnt + 1'b1 : '0;
      run_cnt   <= state == RUN ? run_cnt + 24'd1 : 24'd0;
      if (abort && |op[2:1]) abort_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start_init) begin
            op      <= 3'b001;
            err     <= 1'b0;
            init_ok <= 1'b0;
          end else if (start_frame) begin
            op         <= 3'b010;
            img        <= img_sel;
            blk_cnt    <= 9'd0;
            abort_pend <= 1'b0;
            eof        <= LAST == 9'd0;
          end
        end
        ACK: begin
          if (!sd.if_busy && ack_tmo) begin
            op  <= 3'b000;
            eof <= 1'b0;
            err <= 1'b1;
          end
        end
        RUN: begin
          if (!sd.if_busy) begin
            if (op[0]) begin
              op        <= 3'b000;
              init_ok   <= 1'b1;
              init_done <= 1'b1;
            end else if (op[1]) begin
              op <= 3'b100;
            end else if (eof) begin
              op  <= 3'b000;
              eof <= 1'b0;
            end else begin
              // a late abort still marks the very next block as final
              op      <= 3'b010;
              blk_cnt <= blk_cnt + 9'd1;
              eof     <= blk_cnt + 9'd1 == LAST
                      || abort_pend || abort;
            end
          end else if (run_tmo) begin
            op  <= 3'b000;
            eof <= 1'b0;
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sd.init         = op[0];
  assign sd.read_cmd     = op[1];
  assign sd.stream_512B  = op[2];
  assign sd.end_of_frame = eof;
  assign sd.img_id       = img;

endmodule

// File: tb/tb_sd_frame_seq.sv
// Randomized frame/abort bench for sd_frame_seq with an sd_if stub.
// Expected op sequences are derived from block counts and abort points.
module tb_sd_frame_seq;

  localparam int FB = 5;
  localparam int AT = 16;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] prev;
    logic       eof;
    logic [8:0] blk;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       init_req = 1'b0;
  logic       frame_req = 1'b0;
  logic [3:0] img_sel = 4'd0;
  logic       abort = 1'b0;
  logic       ctl_busy;
  logic       init_ok;
  logic       init_done;
  logic       frame_done;
  logic       aborted;
  logic       err;
  logic [8:0] blk_cnt;
  logic [2:0] cur_op;
  logic [2:0] prev_op = 3'b000;

  int checks = 0;
  int errors = 0;
  int stub_n = 5;
  bit stub_mute = 1'b0;
  int dly;
  int hold;
  rec_t log_q[$];

  sd_frame_seq_if bus();

  sd_frame_seq #(
    .FRAME_BLKS (FB),
    .ACK_TMO    (AT),
    .RUN_TMO    (24'd200)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_req   (init_req),
    .frame_req  (frame_req),
    .img_sel    (img_sel),
    .abort      (abort),
    .ctl_busy   (ctl_busy),
    .init_ok    (init_ok),
    .init_done  (init_done),
    .frame_done (frame_done),
    .aborted    (aborted),
    .err        (err),
    .blk_cnt    (blk_cnt),
    .sd         (bus.master)
  );

  always #5 clk = ~clk;

  assign cur_op = {bus.stream_512B, bus.read_cmd, bus.init};

  // sd_if stub: busy rises ~2 cycles after if_begin, held stub_n cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.if_busy <= 1'b0;
      dly <= 0;
      hold <= 0;
    end else if (bus.if_begin) begin
      if (!stub_mute) dly <= 2;
    end else if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        bus.if_busy <= 1'b1;
        hold <= stub_n;
      end
    end else if (bus.if_busy) begin
      if (hold <= 1) bus.if_busy <= 1'b0;
      else hold <= hold - 1;
    end
  end

  function automatic rec_t mk_rec(
    input logic [2:0] o, input logic [2:0] p,
    input logic e, input logic [8:0] b);
    rec_t r;
    r.op = o;
    r.prev = p;
    r.eof = e;
    r.blk = b;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.if_begin)
      log_q.push_back(mk_rec(cur_op, prev_op, bus.end_of_frame, blk_cnt));
    prev_op <= cur_op;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({ctl_busy, init_ok, init_done, frame_done, aborted, err,
                blk_cnt, bus.init, bus.read_cmd, bus.stream_512B,
                bus.end_of_frame, bus.img_id, bus.if_begin});
  endfunction

  task automatic do_init(input int n, input bit with_frame);
    int cyc;
    stub_n = n;
    log_q.delete();
    @(negedge clk);
    init_req = 1'b1;
    frame_req = with_frame;
    img_sel = 4'd9;
    @(negedge clk);
    init_req = 1'b0;
    frame_req = 1'b0;
    cyc = 0;
    while (!init_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_ok", 32'(init_ok), 32'd1);
    chk("init_err", 32'(err), 32'd0);
    chk("init_nbeg", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) begin
      chk("init_op", 32'(log_q[0].op), 32'b001);
      chk("init_setup", 32'(log_q[0].prev), 32'b001);
    end
    tick(3);
    chk("init_after_op", 32'(cur_op), 32'd0);
    chk("init_after_busy", 32'(ctl_busy), 32'd0);
    chk("init_after_nbeg", 32'(log_q.size()), 32'd1);
  endtask

  // ab < 0: no abort; else abort while block ab is streaming
  task automatic run_frame(input logic [3:0] img, input int ab,
                           input int n);
    int fin;
    int cyc;
    int nexp;
    bit done;
    bit sent;
    bit img_ok;
    rec_t r;
    stub_n = n;
    log_q.delete();
    fin = (ab < 0) ? FB - 1 : ((ab + 1 < FB) ? ab + 1 : FB - 1);
    nexp = 2 * (fin + 1);
    @(negedge clk);
    img_sel = img;
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    img_sel = ~img;
    done = 1'b0;
    sent = 1'b0;
    img_ok = 1'b1;
    cyc = 0;
    while (!done && cyc < 5000) begin
      if (bus.img_id !== img) img_ok = 1'b0;
      if (frame_done) begin
        done = 1'b1;
      end else begin
        if (ab >= 0 && !sent && bus.if_begin && bus.stream_512B
            && blk_cnt == 9'(ab)) begin
          abort = 1'b1;
          sent = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        cyc++;
      end
    end
    chk("frame_done", 32'(done), 32'd1);
    chk("frame_img", 32'(img_ok), 32'd1);
    chk("frame_aborted", 32'(aborted), 32'(ab >= 0));
    chk("frame_blk_end", 32'(blk_cnt), 32'(fin));
    chk("frame_nbeg", 32'(log_q.size()), 32'(nexp));
    for (int i = 0; i < log_q.size() && i < nexp; i++) begin
      r = log_q[i];
      chk($sformatf("op[%0d]", i), 32'(r.op),
          (i % 2) ? 32'b100 : 32'b010);
      chk($sformatf("setup[%0d]", i), 32'(r.prev), 32'(r.op));
      chk($sformatf("eof[%0d]", i), 32'(r.eof), 32'(i / 2 == fin));
      chk($sformatf("blk[%0d]", i), 32'(r.blk), 32'(i / 2));
    end
    tick(1);
    chk("frame_idle", 32'(ctl_busy), 32'd0);
    chk("frame_blk_hold", 32'(blk_cnt), 32'(fin));
  endtask

  task automatic ignored_frame(input string tag);
    bit seen;
    log_q.delete();
    seen = 1'b0;
    @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ctl_busy) seen = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_busy"}, 32'(seen), 32'd0);
    chk({tag, "_nbeg"}, 32'(log_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    #2 rst_n = 1'b0;
    tick(3);
    chk("reset_outs", all_outs(), 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("reset_idle", all_outs(), 32'd0);

    ignored_frame("pre_init");
    do_init(50, 1'b1);

    run_frame(4'd3, -1, 4);
    run_frame(4'd7, 0, 3);
    run_frame(4'd12, FB - 1, 2);
    run_frame(4'd1, FB - 2, 5);
    for (int k = 0; k < 6; k++) begin
      run_frame(4'($urandom_range(0, 15)),
                ($urandom_range(0, 1) == 0) ? -1
                  : int'($urandom_range(0, FB - 1)),
                int'($urandom_range(2, 12)));
    end

    // sd_if never acknowledges the read
    stub_mute = 1'b1;
    log_q.delete();
    @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    cyc = 0;
    while (!bus.if_begin && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("ack_go", 32'(bus.if_begin), 32'd1);
    chk("ack_op", 32'(cur_op), 32'b010);
    cyc = 0;
    while (!err && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("ack_tmo_cyc", 32'(cyc), 32'(AT + 1));
    chk("ack_err_op", 32'(cur_op), 32'd0);
    chk("ack_nbeg", 32'(log_q.size()), 32'd1);
    tick(2);
    chk("ack_idle", 32'(ctl_busy), 32'd0);
    chk("ack_err_sticky", 32'(err), 32'd1);
    stub_mute = 1'b0;

    ignored_frame("post_err");
    do_init(8, 1'b0);
    run_frame(4'd5, -1, 3);

    // reset while block 2 is streaming
    stub_n = 30;
    @(negedge clk);
    img_sel = 4'd10;
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    cyc = 0;
    while (!(bus.if_begin && bus.stream_512B && blk_cnt == 9'd2)
           && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    tick(6);
    chk("rst_pre_busy", 32'(bus.if_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outs", all_outs(), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("rst_init_ok", 32'(init_ok), 32'd0);
    chk("rst_idle", 32'(ctl_busy), 32'd0);
    ignored_frame("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
